// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

    localparam int LDR_ADDR_W     = 6;
    localparam int LDR_DATA_W     = 16;
    localparam int BYTES_PER_WORD = 2;
    localparam int MAX_WORDS      = 2 ** LDR_ADDR_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_LO = 3'd1,
        GET_HI = 3'd2,
        WRITE  = 3'd3,
        RUN    = 3'd4
    } state_t;

    // A length byte of zero stands for a completely full RAM.
    function automatic int decode_len(input logic [7:0] n, input int cap);
        return (n == 8'd0) ? cap : int'(n);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream, RAM write port and processor handshake of the loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DATA_W = LDR_DATA_W
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_w;
    logic              ram_sel;
    logic              run;
    logic              proc_done;
    logic              load_done;
    logic              len_err;

    modport master (
        input  byte_in, byte_valid, proc_done,
        output byte_ready, ram_addr, ram_din, ram_w, ram_sel, run, load_done, len_err
    );

    modport slave (
        output byte_in, byte_valid, proc_done,
        input  byte_ready, ram_addr, ram_din, ram_w, ram_sel, run, load_done, len_err
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles little-endian byte pairs into RAM words, then runs the processor
// until it reports done.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DATA_W = LDR_DATA_W
) (
    input  logic          clock,
    input  logic          reset,
    prog_loader_if.master bus
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int CAP   = 2 ** ADDR_W;

    state_t            r_state, w_state;
    logic [LEN_W-1:0]  r_idx, w_idx;
    logic [LEN_W-1:0]  r_len, w_len;
    logic [7:0]        r_lo, w_lo;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_din, w_din;
    logic              r_w, w_w;
    logic              r_sel, w_sel;
    logic              r_run, w_run;
    logic              r_done, w_done;
    logic              r_len_err, w_len_err;

    logic              w_ready;
    logic              w_xfer;
    int                w_len_dec;

    assign w_ready   = (r_state == IDLE) || (r_state == GET_LO) || (r_state == GET_HI);
    assign w_xfer    = bus.byte_valid && w_ready;
    assign w_len_dec = decode_len(bus.byte_in, CAP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state;
    end

    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_len     = r_len;
        w_lo      = r_lo;
        w_addr    = r_addr;
        w_din     = r_din;
        w_w       = 1'b0;
        w_sel     = r_sel;
        w_run     = r_run;
        w_done    = 1'b0;
        w_len_err = r_len_err;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (w_len_dec > CAP) begin
                        w_len_err = 1'b1;
                    end else begin
                        w_len     = LEN_W'(w_len_dec);
                        w_len_err = 1'b0;
                        w_idx     = '0;
                        w_state   = GET_LO;
                    end
                end
            end
            GET_LO: begin
                if (w_xfer) begin
                    w_lo    = bus.byte_in;
                    w_state = GET_HI;
                end
            end
            GET_HI: begin
                if (w_xfer) begin
                    w_din   = DATA_W'({bus.byte_in, r_lo});
                    w_addr  = r_idx[ADDR_W-1:0];
                    w_w     = 1'b1;
                    w_state = WRITE;
                end
            end
            WRITE: begin
                // The index is one bit wider than the address so a full load ends at CAP-1.
                if (r_idx == r_len - LEN_W'(1)) begin
                    w_sel   = 1'b0;
                    w_run   = 1'b1;
                    w_state = RUN;
                end else begin
                    w_idx   = r_idx + LEN_W'(1);
                    w_state = GET_LO;
                end
            end
            RUN: begin
                if (bus.proc_done) begin
                    w_run   = 1'b0;
                    w_sel   = 1'b1;
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_len     <= '0;
            r_lo      <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_w       <= 1'b0;
            r_sel     <= 1'b1;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_idx     <= w_idx;
            r_len     <= w_len;
            r_lo      <= w_lo;
            r_addr    <= w_addr;
            r_din     <= w_din;
            r_w       <= w_w;
            r_sel     <= w_sel;
            r_run     <= w_run;
            r_done    <= w_done;
            r_len_err <= w_len_err;
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_din    = r_din;
    assign bus.ram_w      = r_w;
    assign bus.ram_sel    = r_sel;
    assign bus.run        = r_run;
    assign bus.load_done  = r_done;
    assign bus.len_err    = r_len_err;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: transaction-level model plus shadow RAM.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    prog_loader_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    prog_loader #(.ADDR_W(6), .DATA_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: counts of words requested and bytes received, plus the run flag.
    int         m_total   = 0;
    int         m_got     = 0;
    bit         m_wpend   = 0;
    bit         m_running = 0;
    logic [7:0] m_buf [0:127];
    logic [5:0] e_addr = '0;
    logic [15:0] e_din = '0;
    bit e_w = 0, e_sel = 1, e_run = 0, e_done = 0, e_lerr = 0;

    initial begin
        int n;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_total = 0; m_got = 0; m_wpend = 0; m_running = 0;
                e_addr = '0; e_din = '0; e_w = 0; e_sel = 1; e_run = 0; e_done = 0; e_lerr = 0;
            end else begin
                e_w = 0;
                e_done = 0;
                if (m_running) begin
                    if (bus.proc_done) begin
                        m_running = 0; e_run = 0; e_sel = 1; e_done = 1; m_total = 0;
                    end
                end else if (m_wpend) begin
                    m_wpend = 0;
                    if (m_got == 2 * m_total) begin
                        m_running = 1; e_run = 1; e_sel = 0;
                    end
                end else if (bus.byte_valid) begin
                    if (m_total == 0) begin
                        n = (bus.byte_in == 8'd0) ? 64 : int'(bus.byte_in);
                        if (n > 64) e_lerr = 1;
                        else begin
                            m_total = n; m_got = 0; e_lerr = 0;
                        end
                    end else begin
                        m_buf[m_got] = bus.byte_in;
                        m_got++;
                        if (m_got % 2 == 0) begin
                            e_w = 1;
                            e_addr = 6'(m_got / 2 - 1);
                            e_din = {bus.byte_in, m_buf[m_got-2]};
                            m_wpend = 1;
                        end
                    end
                end
            end
        end
    end

    // Cycle compare of every output against the model.
    initial begin
        logic [27:0] act_v, exp_v;
        forever begin
            @(negedge clock);
            act_v = {bus.byte_ready, bus.ram_w, bus.ram_sel, bus.run, bus.load_done,
                     bus.len_err, bus.ram_addr, bus.ram_din};
            exp_v = {!m_running && !m_wpend, e_w, e_sel, e_run, e_done, e_lerr, e_addr, e_din};
            check("cycle", 32'(act_v), 32'(exp_v));
        end
    end

    // Shadow RAM fed by the write port.
    logic [15:0] mem [0:63];
    int          wr_addrs [$];

    initial begin
        forever begin
            @(posedge clock);
            if (!reset && bus.ram_w && bus.ram_sel) begin
                mem[bus.ram_addr] = bus.ram_din;
                wr_addrs.push_back(int'(bus.ram_addr));
            end
        end
    end

    logic [15:0] words [0:63];

    task automatic clear_shadow();
        wr_addrs.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (!bus.byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("byte_accept_timeout", 32'(t), 32'(0));
        @(negedge clock);
    endtask

    task automatic wait_run(output bit ok);
        int t;
        t = 0;
        while (!bus.run && t < 40) begin
            @(negedge clock);
            t++;
        end
        ok = bus.run;
        if (!ok) check("run_timeout", 32'(t), 32'(0));
    endtask

    task automatic finish_run(input int dly);
        repeat (dly) @(negedge clock);
        bus.proc_done = 1'b1;
        @(negedge clock);
        check("done_pulse", 32'({bus.load_done, bus.run, bus.ram_sel, bus.byte_ready}), 32'(4'b1011));
        bus.proc_done = 1'b0;
        @(negedge clock);
        check("done_single", 32'(bus.load_done), 32'(0));
    endtask

    task automatic check_mem(input int n);
        check("wr_count", 32'(wr_addrs.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_addrs.size()) check("wr_addr", 32'(wr_addrs[i]), 32'(i));
            check("mem", 32'(mem[i]), 32'(words[i]));
        end
    endtask

    task automatic run_load(input int n, input bit use_zero, input int gapmax, input int dly);
        logic [7:0] lb;
        bit ok;
        clear_shadow();
        for (int i = 0; i < n; i++) words[i] = 16'($urandom);
        lb = (use_zero && n == 64) ? 8'h00 : 8'(n);
        send_byte(lb, $urandom_range(gapmax, 0));
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][7:0], $urandom_range(gapmax, 0));
            send_byte(words[i][15:8], $urandom_range(gapmax, 0));
        end
        bus.byte_valid = 1'b0;
        wait_run(ok);
        if (ok) begin
            check_mem(n);
            finish_run(dly);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, 32'({bus.byte_ready, bus.ram_w, bus.ram_sel, bus.run, bus.load_done,
                         bus.len_err, bus.ram_addr, bus.ram_din}),
              32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.proc_done = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_vals("reset_state");
        reset = 1'b0;
        @(negedge clock);

        // proc_done outside RUN has no effect
        bus.proc_done = 1'b1;
        @(negedge clock);
        bus.proc_done = 1'b0;
        @(negedge clock);
        check("idle_done_ignored", 32'({bus.run, bus.load_done, bus.ram_sel}), 32'(3'b001));

        // Basic load with byte_valid held continuously
        clear_shadow();
        send_byte(8'h02, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        bus.byte_valid = 1'b0;
        check("basic_in_write", 32'({bus.ram_w, bus.ram_addr, bus.ram_din}), 32'({1'b1, 6'd1, 16'hABCD}));
        wait_run(ok);
        check("basic_count", 32'(wr_addrs.size()), 32'(2));
        check("basic_mem0", 32'(mem[0]), 32'h1234);
        check("basic_mem1", 32'(mem[1]), 32'hABCD);
        check("basic_run", 32'({bus.run, bus.ram_sel, bus.byte_ready}), 32'(3'b100));
        finish_run(3);

        // Oversized length is rejected, then a valid length clears the flag
        clear_shadow();
        send_byte(8'h46, 0);
        bus.byte_valid = 1'b0;
        check("len_err_set", 32'({bus.len_err, bus.byte_ready, bus.ram_w}), 32'(3'b110));
        @(negedge clock);
        check("len_err_no_write", 32'(wr_addrs.size()), 32'(0));
        words[0] = 16'h5A3C;
        send_byte(8'h01, 1);
        check("len_err_clear", 32'(bus.len_err), 32'(0));
        send_byte(8'h3C, 0);
        send_byte(8'h5A, 2);
        bus.byte_valid = 1'b0;
        wait_run(ok);
        check_mem(1);
        finish_run(0);

        // Full capacity, length byte zero
        run_load(64, 1'b1, 0, 1);
        check("full_last_addr", 32'(wr_addrs.size() > 0 ? wr_addrs[wr_addrs.size()-1] : -1), 32'(63));

        // Randomized loads
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(3, 0) == 0) begin
                send_byte(8'($urandom_range(255, 65)), $urandom_range(2, 0));
                bus.byte_valid = 1'b0;
                check("rand_len_err", 32'(bus.len_err), 32'(1));
            end
            run_load($urandom_range(64, 1), $urandom_range(1, 0), 2, $urandom_range(5, 0));
        end
        run_load(64, 1'b0, 1, 2);

        // Reset mid-load: length 4 plus two data bytes accepted
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        bus.byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals("reset_midload");
        @(negedge clock);
        reset = 1'b0;
        run_load(3, 1'b0, 1, 1);

        // Reset during RUN
        clear_shadow();
        words[0] = 16'hBEEF;
        send_byte(8'h01, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        bus.byte_valid = 1'b0;
        wait_run(ok);
        #3 reset = 1'b1;
        #1 check_reset_vals("reset_in_run");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_load(2, 1'b0, 0, 0);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the RAM/processor pair: accepts a byte stream and assembles 16-bit instruction/data words.
- Writes those words into the 64-word program RAM starting at address 0.
- Then hands RAM ownership to the processor and holds its run input until the processor reports done.
- Owns the RAM write port through an external mux selected by ram_sel.

Parameters:
ADDR_W, 6, RAM address width; word capacity = 2**ADDR_W.
DATA_W, 16, RAM word width; fixed at 2 bytes per word.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
byte_in  in  8  stream byte
byte_valid  in  1  byte_in valid this cycle
byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready at a rising edge
ram_addr  out  ADDR_W  RAM write address
ram_din  out  DATA_W  RAM write data
ram_w  out  1  RAM write enable, one-cycle pulse per word
ram_sel  out  1  1 = loader drives RAM port, 0 = processor drives it
run  out  1  processor run level
proc_done  in  1  processor done flag
load_done  out  1  one-cycle pulse when processor done is observed
len_err  out  1  sticky: last length byte exceeded capacity

Behaviour:
- Reset values: state IDLE, byte_ready 1, ram_addr 0, ram_din 0, ram_w 0, ram_sel 1, run 0, load_done 0, len_err 0, word index 0, length 0.
- Reset is honoured in any state, including mid-load or during RUN. run drops immediately on reset assertion, and ram_sel returns to 1.
- byte_ready is decoded from state: 1 in IDLE, GET_LO and GET_HI; 0 in all other states.
- All other outputs are registered.
- IDLE (awaiting the length byte): on a transfer, byte_in is the word count N.
  - N = 0 is interpreted as 2**ADDR_W (64).
  - If 1 <= N <= 64 (or 0): store the length, clear len_err, set index to 0, go to GET_LO.
  - If N > 64: set len_err = 1 and stay in IDLE; no RAM write occurs.
- GET_LO: on a transfer, latch the low byte and go to GET_HI.
- GET_HI: on a transfer, load ram_din = {byte_in, lo}, ram_addr = index and ram_w = 1 at the same edge, then go to WRITE.
  - The write is therefore visible to the RAM at the next rising edge, one cycle after the high byte is accepted.
- WRITE: lasts exactly one cycle; ram_w returns to 0 at its end.
  - If index == length-1: go to RUN; ram_sel goes to 0 and run goes to 1 at that edge.
  - Otherwise: increment index and go to GET_LO.
- Index width is ADDR_W+1 so that a 64-word load terminates without wrap; ram_addr carries index[ADDR_W-1:0].
- RUN: run = 1, ram_sel = 0, bytes are not accepted.
  - When proc_done is sampled 1: run = 0, ram_sel = 1, load_done = 1 for one cycle, go to IDLE.
- proc_done in any state other than RUN is ignored.
- A byte_valid while byte_ready = 0 is neither consumed nor buffered. The source must hold the byte until it is accepted.
- No timeout: a stalled stream leaves the block waiting in GET_LO/GET_HI indefinitely. Only reset recovers.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, GET_LO, GET_HI, WRITE, RUN), binary encoded;
  - the constants BYTES_PER_WORD = 2 and MAX_WORDS = 2**ADDR_W.
- Single module; no sub-module needed.
- The external RAM port mux (selected by ram_sel) lives in the enclosing top, not in this block.

Test Plan:
- Basic load: stream 0x02, 0x34, 0x12, 0xCD, 0xAB → ram_w pulses twice, writing 0x1234 @0 and 0xABCD @1. run rises the cycle after the second write; ram_sel = 0.
- Full capacity: length 0x00 followed by 128 bytes → 64 writes at addresses 0..63 with no wrap to 0. run asserts after the write to address 63.
- Length error: length 0x46 (70) → len_err = 1, no ram_w, byte_ready stays 1. A following length 0x01 clears len_err and loads normally.
- Handshake hold: byte_valid held high continuously with the stream → exactly one byte consumed per ready cycle; no byte consumed during WRITE or RUN; data order intact.
- Done handling: proc_done pulsed in IDLE → ignored. In RUN, proc_done = 1 → next cycle run = 0, ram_sel = 1, load_done single-cycle pulse, byte_ready = 1.
- Reset mid-operation: assert reset after 3 bytes of a 4-word load, and again during RUN → all outputs return to reset values asynchronously. A fresh load afterwards writes from address 0.
